// File: rtl/mmio_regfile_axil.sv
// MMIO register-file slave on an AXI-lite style channel set: byte strobes,
// decoupled AW/W capture, pipelined reads through a response FIFO, full decode.
module mmio_regfile_axil #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int NUM_REGS      = 1024,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int PROTECT_REG0  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int S      = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int PTR_W  = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = DATA_WIDTH + 2;
    localparam logic [1:0]       RESP_OKAY   = 2'd0;
    localparam logic [1:0]       RESP_SLVERR = 2'd2;
    localparam logic [1:0]       RESP_DECERR = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(RD_FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    // Priority decode: misalignment beats out-of-range beats the protected register.
    function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] hi;
        hi = addr >> (S + IDX_W);
        if (addr[S-1:0] != {S{1'b0}})
            decode = RESP_SLVERR;
        else if (hi != {ADDR_WIDTH{1'b0}})
            decode = RESP_DECERR;
        else if ((addr[S +: IDX_W] == {IDX_W{1'b0}}) && (PROTECT_REG0 != 0))
            decode = RESP_DECERR;
        else
            decode = RESP_OKAY;
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [ENT_W-1:0]      r_fifo [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_aw_full;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_full;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [1:0]            w_ar_resp;
    logic [DATA_WIDTH-1:0] w_ar_data;
    logic [ENT_W-1:0]      w_head;
    logic                  w_commit;
    logic [1:0]            w_wr_resp;
    logic [IDX_W-1:0]      w_wr_idx;

    assign arready   = (r_count != CNT_FULL);
    assign rvalid    = (r_count != {CNT_W{1'b0}});
    assign w_ar_hs   = arvalid && arready;
    assign w_r_hs    = rvalid && rready;
    assign w_ar_resp = decode(araddr);
    assign w_ar_data = (w_ar_resp == RESP_OKAY) ? r_regs[araddr[S +: IDX_W]] : {DATA_WIDTH{1'b0}};
    assign w_head    = r_fifo[r_rptr];
    // Empty FIFO shows zeros so stale entries never leak onto the bus.
    assign rdata     = rvalid ? w_head[ENT_W-1:2] : {DATA_WIDTH{1'b0}};
    assign rresp     = rvalid ? w_head[1:0] : 2'b00;

    assign awready   = !r_aw_full;
    assign wready    = !r_w_full;
    assign w_commit  = r_aw_full && r_w_full && (!r_bvalid || bready);
    assign w_wr_resp = decode(r_aw_addr);
    assign w_wr_idx  = r_aw_addr[S +: IDX_W];
    assign bvalid    = r_bvalid;
    assign bresp     = r_bresp;

    // Read response FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_ar_hs) r_wptr <= r_wptr + PTR_ONE;
            if (w_r_hs)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_ar_hs, w_r_hs})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Read response FIFO storage; data is snapshotted at AR acceptance.
    always_ff @(posedge clk) begin
        if (w_ar_hs) r_fifo[r_wptr] <= {w_ar_data, w_ar_resp};
    end

    // AW/W holding registers and the B channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= {ADDR_WIDTH{1'b0}};
            r_w_full  <= 1'b0;
            r_w_data  <= {DATA_WIDTH{1'b0}};
            r_w_strb  <= {STRB_W{1'b0}};
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            if (w_commit) begin
                r_aw_full <= 1'b0;
            end else if (awvalid && !r_aw_full) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= awaddr;
            end
            if (w_commit) begin
                r_w_full <= 1'b0;
            end else if (wvalid && !r_w_full) begin
                r_w_full <= 1'b1;
                r_w_data <= wdata;
                r_w_strb <= wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_resp;
            end else if (bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register storage is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_commit && (w_wr_resp == RESP_OKAY)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (r_w_strb[i]) r_regs[w_wr_idx][8*i +: 8] <= r_w_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mmio_regfile_axil.sv
// Scoreboard bench for mmio_regfile_axil: directed scenarios plus random
// traffic checked against an address-arithmetic reference model.
module tb_mmio_regfile_axil;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int NR = 1024;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] araddr, awaddr;
    logic [DW-1:0] rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [7:0]    wstrb;

    always #5 clk = ~clk;

    mmio_regfile_axil #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
        .RD_FIFO_DEPTH(FD), .PROTECT_REG0(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
    } rexp_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    rexp_t       rq[$];
    logic [1:0]  bq[$];
    logic [63:0] mdl [NR];
    bit          rnd_ready = 1'b0;
    rexp_t       mon_e;
    logic [1:0]  mon_b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference decode from plain address arithmetic.
    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        if (a % 8 != 0) return 2'd2;
        if (a / 8 >= NR) return 2'd3;
        if (a / 8 == 0) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [1:0] r;
        r = exp_resp(a);
        if (r == 2'd0) begin
            for (int i = 0; i < 8; i++)
                if (s[i]) mdl[int'(a / 8)][8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Monitor: compare whenever a response handshake is about to complete.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid && rready) begin
                if (rq.size() == 0) chk("unexpected_r", 64'd1, 64'd0);
                else begin
                    mon_e = rq.pop_front();
                    chk("rdata", rdata, mon_e.d);
                    chk("rresp", 64'(rresp), 64'(mon_e.r));
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) chk("unexpected_b", 64'd1, 64'd0);
                else begin
                    mon_b = bq.pop_front();
                    chk("bresp", 64'(bresp), 64'(mon_b));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) begin
            rready = ($urandom_range(0, 3) != 0);
            bready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drive_aw_w(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                              input int aw_dly, input int w_dly);
        bit aw_done = 1'b0, w_done = 1'b0, awh, wh;
        awaddr = a; wdata = d; wstrb = s;
        for (int c = 0; c < 200 && !(aw_done && w_done); c++) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            awh = awvalid && awready;
            wh  = wvalid && wready;
            tick();
            if (awh) aw_done = 1'b1;
            if (wh)  w_done = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) chk("aw_w_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_b();
        for (int c = 0; c < 200 && bq.size() != 0; c++) tick();
        if (bq.size() != 0) chk("b_timeout", 64'(bq.size()), 64'd0);
    endtask

    task automatic wait_r();
        for (int c = 0; c < 400 && rq.size() != 0; c++) tick();
        if (rq.size() != 0) chk("r_timeout", 64'(rq.size()), 64'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int aw_dly, input int w_dly);
        bq.push_back(model_write(a, d, s));
        drive_aw_w(a, d, s, aw_dly, w_dly);
        wait_b();
    endtask

    // Issues one read; the caller drops arvalid after the last one of a burst.
    task automatic issue_read_c(input logic [31:0] a, input logic [63:0] d, input logic [1:0] r);
        bit ok = 1'b0;
        rexp_t e;
        arvalid = 1'b1; araddr = a;
        e.d = d; e.r = r;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (arready) begin
                rq.push_back(e);
                ok = 1'b1;
            end
            tick();
        end
        if (!ok) chk("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue_read(input logic [31:0] a);
        logic [1:0] r;
        r = exp_resp(a);
        issue_read_c(a, (r == 2'd0) ? mdl[int'(a / 8)] : 64'd0, r);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 19);
        if (k == 0)      return 32'($urandom_range(0, 40) * 8 + $urandom_range(1, 7));
        else if (k == 1) return 32'((NR + $urandom_range(0, 3)) * 8);
        else if (k == 2) return 32'((NR - 1) * 8);
        else             return 32'($urandom_range(0, 40) * 8);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        bit h;
        rst_n = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b1;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1;
        #12;
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        #20 rst_n = 1'b1;
        tick();

        // Give every register used below a known value.
        for (int i = 1; i <= 40; i++) do_write(32'(i * 8), {$urandom, $urandom}, 8'hFF, 0, 0);
        do_write(32'((NR - 1) * 8), {$urandom, $urandom}, 8'hFF, 0, 0);

        // Full write then read back, including single-cycle read latency.
        do_write(32'h8, 64'h1122334455667788, 8'hFF, 0, 0);
        issue_read_c(32'h8, 64'h1122334455667788, 2'd0);
        arvalid = 1'b0;
        chk("rvalid_latency", 64'(rvalid), 64'd1);
        wait_r();
        // Partial strobe merges into the old value.
        do_write(32'h8, 64'hAA, 8'h01, 1, 0);
        issue_read_c(32'h8, 64'h11223344556677AA, 2'd0);
        arvalid = 1'b0;
        wait_r();

        // W arrives three cycles ahead of AW.
        bq.push_back(model_write(32'h10, 64'd5, 8'hFF));
        wvalid = 1'b1; wdata = 64'd5; wstrb = 8'hFF;
        tick();
        wvalid = 1'b0;
        chk("wready_after_w", 64'(wready), 64'd0);
        chk("awready_still_free", 64'(awready), 64'd1);
        tick(); tick();
        chk("no_commit_without_aw", 64'(bvalid), 64'd0);
        awvalid = 1'b1; awaddr = 32'h10;
        tick();
        awvalid = 1'b0;
        wait_b();
        issue_read_c(32'h10, 64'd5, 2'd0);
        arvalid = 1'b0;
        wait_r();

        // Five reads against a blocked R channel: only the FIFO depth is accepted.
        rready = 1'b0; accepted = 0;
        arvalid = 1'b1; araddr = 32'h8;
        for (int c = 0; c < 8; c++) begin
            h = arready;
            if (h) rq.push_back('{mdl[int'(araddr / 8)], 2'd0});
            tick();
            if (h) begin accepted++; araddr = 32'((accepted + 1) * 8); end
            if (accepted == 5) arvalid = 1'b0;
        end
        chk("ar_accepts_blocked", 64'(accepted), 64'd4);
        chk("arready_full", 64'(arready), 64'd0);
        rready = 1'b1;
        for (int c = 0; c < 20 && accepted < 5; c++) begin
            h = arready && arvalid;
            if (h) rq.push_back('{mdl[int'(araddr / 8)], 2'd0});
            tick();
            if (h) begin accepted++; arvalid = 1'b0; end
        end
        arvalid = 1'b0;
        chk("fifth_read_accepted", 64'(accepted), 64'd5);
        wait_r();

        // Error decode on both channels.
        do_write(32'h0, 64'd7, 8'hFF, 0, 0);
        issue_read_c(32'h0, 64'd0, 2'd3);
        issue_read_c(32'h4, 64'd0, 2'd2);
        issue_read_c(32'(NR * 8), 64'd0, 2'd3);
        arvalid = 1'b0;
        wait_r();

        // Second write must wait for the first B handshake.
        bready = 1'b0;
        bq.push_back(model_write(32'h18, 64'hDEAD_BEEF_0000_0018, 8'hFF));
        drive_aw_w(32'h18, 64'hDEAD_BEEF_0000_0018, 8'hFF, 0, 0);
        for (int c = 0; c < 20 && !bvalid; c++) tick();
        chk("first_bvalid", 64'(bvalid), 64'd1);
        bq.push_back(model_write(32'h20, 64'hCAFE_0000_0000_0020, 8'hF0));
        drive_aw_w(32'h20, 64'hCAFE_0000_0000_0020, 8'hF0, 0, 1);
        tick(); tick(); tick();
        chk("second_aw_held", 64'(awready), 64'd0);
        chk("second_b_pending", 64'(bq.size()), 64'd2);
        bready = 1'b1;
        wait_b();

        // Reset with a pending B, queued reads and a half-delivered write.
        bready = 1'b0;
        void'(model_write(32'h28, 64'h0123_4567_89AB_CDEF, 8'hFF));
        drive_aw_w(32'h28, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0);
        for (int c = 0; c < 20 && !bvalid; c++) tick();
        rready = 1'b0;
        issue_read(32'h8);
        issue_read(32'h10);
        arvalid = 1'b0;
        awvalid = 1'b1; awaddr = 32'h30;
        tick();
        awvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_bvalid", 64'(bvalid), 64'd0);
        chk("midrst_rvalid", 64'(rvalid), 64'd0);
        chk("midrst_awready", 64'(awready), 64'd1);
        chk("midrst_arready", 64'(arready), 64'd1);
        rq.delete(); bq.delete();
        #2 rst_n = 1'b1;
        rready = 1'b1; bready = 1'b1;
        tick();
        for (int i = 1; i <= 6; i++) issue_read(32'(i * 8));
        arvalid = 1'b0;
        wait_r();

        // Random mixed traffic with random back-pressure.
        rnd_ready = 1'b1;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(rand_addr(), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                for (int j = 0; j < int'($urandom_range(1, 6)); j++) issue_read(rand_addr());
                arvalid = 1'b0;
            end
        end
        wait_r();
        wait_b();
        rnd_ready = 1'b0;
        rready = 1'b1; bready = 1'b1;
        tick();
        chk("final_r_queue_empty", 64'(rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_regfile_axil.md
Name: mmio_regfile_axil

Overview:
Parametrised MMIO register-file slave on the cosim MMIO (AXI-lite style) channel set. Generalises the single-outstanding 32-bit test memory in five ways: configurable data width and depth, byte write strobes, decoupled AW/W acceptance, multiple outstanding reads via a response FIFO, and full address decode with distinct error codes. Sits behind the Cosim_MMIO endpoint as the target for runtime MMIO integration tests.

Parameters:
DATA_WIDTH, 64, register and bus data width in bits; 32 or 64.
ADDR_WIDTH, 32, byte-address width.
NUM_REGS, 1024, number of registers; power of two, at least 2.
RD_FIFO_DEPTH, 4, number of outstanding read responses; power of two, at least 2.
PROTECT_REG0, 1, when 1, accesses to register 0 return DECERR and do not write.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
araddr  in  ADDR_WIDTH  read byte address.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
rdata  out  DATA_WIDTH  read data.
rresp  out  2  read response.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
awaddr  in  ADDR_WIDTH  write byte address.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
wdata  in  DATA_WIDTH  write data.
wstrb  in  DATA_WIDTH/8  byte write enables.
bvalid  out  1  write response valid.
bready  in  1  write response ready.
bresp  out  2  write response.

Behaviour:
- Reset (rst_n low, asynchronous): rvalid=0, bvalid=0, bresp=0, rresp=0, rdata=0. Read FIFO empty, so arready=1. AW/W holding registers empty, so awready=1 and wready=1. Register contents are not reset and are retained across reset.
- Decode: S = log2(DATA_WIDTH/8); idx = addr >> S. Checks apply in priority order:
  - addr[S-1:0] != 0 -> SLVERR (2).
  - idx >= NUM_REGS -> DECERR (3).
  - idx == 0 and PROTECT_REG0 -> DECERR (3).
  - otherwise OKAY (0).
- Read path:
  - AR handshake is arvalid && arready. arready = FIFO not full; a pop in the same cycle does not free a slot.
  - On handshake, {data, resp} is pushed into the FIFO. data = regs[idx] on OKAY, 0 on any error.
  - rvalid = FIFO not empty. rdata and rresp come from the FIFO head. Pop on rvalid && rready.
  - Minimum latency: rvalid is high the cycle after the AR handshake.
  - Responses return in acceptance order. Push and pop in the same cycle are both allowed.
- Write path:
  - awready = AW holder empty; wready = W holder empty. AW and W are captured independently, in either order or in the same cycle.
  - Commit occurs in the cycle where both holders are full and (!bvalid || bready). On commit:
    - on OKAY, bytes with wstrb[i]=1 are written to regs[idx];
    - bvalid is set, bresp is set to the decode result, and both holders are cleared.
  - On error, no register is written.
  - Back-to-back: a new AW/W may be captured the cycle after commit. Each new commit waits for the prior B handshake, or coincides with it.
  - bvalid drops after bvalid && bready unless a commit occurs in the same cycle.
- Read/write ordering:
  - A read accepted in the same cycle as a commit returns the old data.
  - A read accepted one or more cycles after a commit returns the new data.
- Reset mid-operation: pending read responses and held AW/W are discarded with no response. Committed writes persist.

Test Plan:
- Write addr 0x8, wdata 0x1122334455667788, wstrb 0xFF -> bresp 0. Then read 0x8 -> rdata 0x1122334455667788, rresp 0.
- Write addr 0x8, wdata 0xAA, wstrb 0x01 over the previous value -> read 0x8 returns 0x11223344556677AA.
- W presented 3 cycles before AW (addr 0x10, data 5) -> wready drops after W capture. Commit happens only after AW. Read 0x10 returns 5.
- With rready held low, issue 5 reads -> arready drops after 4 accepts. Raise rready -> 4 responses return in order. Then the 5th read is accepted and returns.
- Write addr 0x0, data 7 -> bresp 3; read 0x0 -> rresp 3, rdata 0. Read 0x4 -> rresp 2. Read addr 1024*8 -> rresp 3.
- Hold bready low after a write, then present a second AW/W -> second bvalid does not issue until the first B handshake. Assert rst_n low mid-transaction -> bvalid/rvalid go to 0 immediately and previously committed data reads back unchanged.
